inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  hold PC and IF/ID register.
REQ-005 flush  input  1  exception flush; redirect to flush_pc.
REQ-006 flush_pc  input  pc_t  exception handler address.
REQ-007 branch_taken  input  1  redirect request from ID.
REQ-008 branch_target  input  pc_t  redirect address.
REQ-009 rom_ce  output  chip_status_t  instruction ROM chip enable.
REQ-010 rom_pc  output  pc_t  instruction ROM address, byte address.
REQ-011 rom_inst  input  inst_t  ROM read data, combinational from rom_ce/rom_pc in the same cycle.
REQ-012 id_pc  output  pc_t  IF/ID registered PC.
REQ-013 id_inst  output  inst_t  IF/ID registered instruction.
REQ-014 id_valid  output  1  IF/ID register holds a real fetch.

Function
REQ-015 The block SHALL be a two-state FSM: IDLE (rom_ce=CHIP_DISABLE) and RUN (rom_ce=CHIP_ENABLE).
REQ-016 IDLE -> RUN at the first rising edge with rst low; rom_pc SHALL stay at RESET_PC on that edge.
REQ-017 In RUN, the next rom_pc SHALL be selected in priority order: flush_pc (flush) > held (stall) > pending redirect > branch_target (branch_taken) > rom_pc+4.
REQ-018 PC+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-019 branch_taken asserted while stall is high SHALL be latched into a one-entry pending-redirect register and applied on the first unstalled edge.
REQ-020 The pending redirect SHALL be cleared when applied and on flush; a later branch_taken during the same stall SHALL overwrite it.
REQ-021 Simultaneous flush and stall SHALL apply flush (flush overrides stall).
REQ-022 IF/ID update: flush -> id_inst=0, id_valid=0, id_pc=0; stall -> hold all three; otherwise capture rom_pc, rom_inst, and id_valid = (rom_ce==CHIP_ENABLE).
REQ-023 IF-to-ID latency SHALL be one cycle; sustained throughput SHALL be one instruction per unstalled cycle.
REQ-024 The instruction in IF when branch_taken is sampled (the delay slot) SHALL proceed to ID normally.

Reset
REQ-025 While rst is high: FSM=IDLE, rom_ce=CHIP_DISABLE, rom_pc=RESET_PC, pending redirect cleared, id_pc=0, id_inst=0, id_valid=0.
REQ-026 rst asserted mid-stream SHALL override flush, stall and branch_taken on that edge.

Configuration
REQ-027 Macro FETCH_ALIGN_CHECK_EN. When defined, a redirect or flush target with [1:0]!=0 SHALL be fetched with rom_ce=CHIP_DISABLE; the IF/ID register SHALL capture id_inst=0, id_valid=1, and assert an extra output id_exc_adel (1 bit).
REQ-028 When FETCH_ALIGN_CHECK_EN is undefined, target bits [1:0] SHALL be forced to 0 silently and id_exc_adel SHALL not exist.

Structure
REQ-029 pc_t, inst_t, chip_status_t (CHIP_ENABLE/CHIP_DISABLE) and the FSM state enum SHALL live in project_types.
REQ-030 One sub-module, pc_reg (FSM, PC and pending redirect), is natural; the IF/ID register stays in inst_fetch.

Verification
REQ-031 Reset release, RESET_PC=0, no stall -> rom_ce enabled cycle 1; rom_pc 0,4,8; id_pc follows one cycle later with id_valid=1.
REQ-032 branch_taken, branch_target=32'h100 at rom_pc=8 -> delay slot at C reaches ID; next rom_pc=100.
REQ-033 stall high 3 cycles, branch_taken during cycle 1 only -> PC and IF/ID held; rom_pc=branch_target on the first unstalled edge.
REQ-034 flush with stall, flush_pc=32'h180 -> next rom_pc=180; id_valid=0, id_inst=0; pending redirect dropped.
REQ-035 rom_pc=32'hFFFF_FFFC, no events -> next rom_pc=0.
REQ-036 With FETCH_ALIGN_CHECK_EN, branch_target=32'h102 -> rom_ce disabled for that fetch; next cycle id_exc_adel=1, id_inst=0, id_valid=1.

Source files
------------

// File: rtl/project_types.sv
// ============================================================================
// Module      : project_types (package)
// Description : Shared types for the instruction-fetch stage: PC and
//               instruction words, ROM chip-enable status, fetch FSM states,
//               and the redirect-target conditioning helper.
//               Optional feature macro: FETCH_ALIGN_CHECK_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package project_types;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] inst_t;

  typedef enum logic [0:0] {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } chip_status_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  localparam pc_t c_PC_STEP = 32'd4;

  // Redirect/flush targets: passed through untouched when the alignment
  // check is built in (the fetch stage flags them), otherwise word-aligned.
  function automatic pc_t fetch_target(input pc_t t);
`ifdef FETCH_ALIGN_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module      : pc_reg
// Description : Fetch FSM (IDLE/RUN), program counter and one-entry pending
//               redirect that remembers a branch requested during a stall.
//               Optional feature macro: FETCH_ALIGN_CHECK_EN (adds fetch_adel)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg
  import project_types::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  pc_t          flush_pc,
  input  logic         branch_taken,
  input  pc_t          branch_target,
  output chip_status_t rom_ce,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic         fetch_adel,
`endif
  output pc_t          rom_pc
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  pc_t          r_pc;
  pc_t          w_pc_next;
  logic         r_pend_vld;
  logic         w_pend_vld_next;
  pc_t          r_pend_pc;
  pc_t          w_pend_pc_next;

  // State register: FSM, PC and pending redirect; reset beats every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_pend_vld <= 1'b0;
      r_pend_pc  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_pend_vld <= w_pend_vld_next;
      r_pend_pc  <= w_pend_pc_next;
    end
  end

  // Next-state logic: flush > stall (hold, latch branch) > pending > branch > +4.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_pend_vld_next = r_pend_vld;
    w_pend_pc_next  = r_pend_pc;
    case (r_state)
      ST_IDLE: begin
        // PC stays at RESET_PC on the leaving edge so it is the first fetch.
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (flush) begin
          w_pc_next       = fetch_target(flush_pc);
          w_pend_vld_next = 1'b0;
        end else if (stall) begin
          if (branch_taken) begin
            w_pend_vld_next = 1'b1;
            w_pend_pc_next  = fetch_target(branch_target);
          end
        end else if (r_pend_vld) begin
          w_pc_next       = r_pend_pc;
          w_pend_vld_next = 1'b0;
        end else if (branch_taken) begin
          w_pc_next = fetch_target(branch_target);
        end else begin
          // 32-bit add wraps FFFF_FFFC -> 0000_0000 naturally.
          w_pc_next = r_pc + c_PC_STEP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic: ROM enabled only in RUN (and, when checked, on aligned PCs).
  always_comb begin
    rom_pc = r_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_adel = (r_state == ST_RUN) && (r_pc[1:0] != 2'b00);
    rom_ce     = ((r_state == ST_RUN) && (r_pc[1:0] == 2'b00)) ? CHIP_ENABLE : CHIP_DISABLE;
`else
    rom_ce     = (r_state == ST_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module      : inst_fetch
// Description : Instruction fetch stage: PC generation (pc_reg) driving a
//               combinational instruction ROM, plus the IF/ID pipeline register.
//               Optional feature macro: FETCH_ALIGN_CHECK_EN (adds id_exc_adel)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch
  import project_types::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  pc_t          flush_pc,
  input  logic         branch_taken,
  input  pc_t          branch_target,
  output chip_status_t rom_ce,
  output pc_t          rom_pc,
  input  inst_t        rom_inst,
  output pc_t          id_pc,
  output inst_t        id_inst,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic         id_exc_adel,
`endif
  output logic         id_valid
);

`ifdef FETCH_ALIGN_CHECK_EN
  logic w_fetch_adel;
`endif

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .rom_ce        (rom_ce),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_adel    (w_fetch_adel),
`endif
    .rom_pc        (rom_pc)
  );

  // IF/ID register: flush squashes to a bubble, stall holds, else capture the fetch.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc       <= '0;
      id_inst     <= '0;
      id_valid    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      id_exc_adel <= 1'b0;
`endif
    end else if (!stall) begin
      id_pc       <= rom_pc;
`ifdef FETCH_ALIGN_CHECK_EN
      // A misaligned fetch travels on as a valid slot carrying the exception.
      id_inst     <= w_fetch_adel ? '0 : rom_inst;
      id_valid    <= (rom_ce == CHIP_ENABLE) || w_fetch_adel;
      id_exc_adel <= w_fetch_adel;
`else
      id_inst     <= rom_inst;
      id_valid    <= (rom_ce == CHIP_ENABLE);
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module      : tb_inst_fetch
// Description : Directed self-checking bench for inst_fetch with a
//               combinational ROM model. Covers the FETCH_ALIGN_CHECK_EN
//               build when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;
  import project_types::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         flush;
  pc_t          flush_pc;
  logic         branch_taken;
  pc_t          branch_target;
  chip_status_t rom_ce;
  pc_t          rom_pc;
  inst_t        rom_inst;
  pc_t          id_pc;
  inst_t        id_inst;
  logic         id_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         id_exc_adel;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ROM contents: a fixed, address-dependent pattern.
  function automatic inst_t rom_word(input pc_t a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign rom_inst = rom_word(rom_pc);

  inst_fetch #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .rom_ce        (rom_ce),
    .rom_pc        (rom_pc),
    .rom_inst      (rom_inst),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
`ifdef FETCH_ALIGN_CHECK_EN
    .id_exc_adel   (id_exc_adel),
`endif
    .id_valid      (id_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input pc_t pc, input logic vld);
    chk({tag, ".id_pc"}, id_pc, pc);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, vld});
    chk({tag, ".id_inst"}, id_inst, vld ? rom_word(pc) : 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = '0;
    branch_taken = 1'b0; branch_target = '0;
    step(); step();

    // Reset state
    chk("rst.rom_ce", {31'd0, rom_ce}, {31'd0, CHIP_DISABLE});
    chk("rst.rom_pc", rom_pc, 32'h0);
    chk_id("rst", 32'h0, 1'b0);

    // Reset release: IDLE -> RUN, PC held at RESET_PC
    rst = 1'b0;
    step();
    chk("run.rom_ce", {31'd0, rom_ce}, {31'd0, CHIP_ENABLE});
    chk("run.rom_pc0", rom_pc, 32'h0);
    chk("run.id_valid0", {31'd0, id_valid}, 32'd0);
    step();
    chk("seq.rom_pc4", rom_pc, 32'h4);
    chk_id("seq0", 32'h0, 1'b1);
    step();
    chk("seq.rom_pc8", rom_pc, 32'h8);
    chk_id("seq4", 32'h4, 1'b1);
    step();
    chk("seq.rom_pcC", rom_pc, 32'hC);

    // Branch at 8 resolved in ID; delay slot C proceeds, next fetch 0x100
    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    chk("br.rom_pc", rom_pc, 32'h100);
    chk_id("br.slot", 32'hC, 1'b1);
    step();
    chk("br.rom_pc104", rom_pc, 32'h104);
    chk_id("br.tgt", 32'h100, 1'b1);

    // Stall 3 cycles, branch only in the first: hold, then redirect
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    chk("stl1.rom_pc", rom_pc, 32'h104);
    chk_id("stl1", 32'h100, 1'b1);
    step();
    chk("stl2.rom_pc", rom_pc, 32'h104);
    step();
    chk("stl3.rom_pc", rom_pc, 32'h104);
    chk_id("stl3", 32'h100, 1'b1);
    stall = 1'b0;
    step();
    chk("stl.redir", rom_pc, 32'h200);
    chk_id("stl.rel", 32'h104, 1'b1);

    // Later branch in the same stall overwrites the pending redirect
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    step();
    branch_target = 32'h340;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    step();
    chk("ovw.rom_pc", rom_pc, 32'h340);
    chk_id("ovw", 32'h200, 1'b1);

    // Flush with stall and a pending redirect: flush wins, pending dropped
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h400;
    step();
    branch_taken = 1'b0; flush = 1'b1; flush_pc = 32'h180;
    step();
    flush = 1'b0; stall = 1'b0;
    chk("fl.rom_pc", rom_pc, 32'h180);
    chk_id("fl", 32'h0, 1'b0);
    step();
    chk("fl.nopend", rom_pc, 32'h184);
    chk_id("fl.next", 32'h180, 1'b1);

    // PC wrap FFFF_FFFC -> 0
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    chk("wrap.top", rom_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap.zero", rom_pc, 32'h0);
    chk_id("wrap", 32'hFFFF_FFFC, 1'b1);

    // Misaligned redirect target
    branch_taken = 1'b1; branch_target = 32'h102;
    step();
    branch_taken = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("adel.rom_pc", rom_pc, 32'h102);
    chk("adel.rom_ce", {31'd0, rom_ce}, {31'd0, CHIP_DISABLE});
    step();
    chk("adel.id_exc", {31'd0, id_exc_adel}, 32'd1);
    chk("adel.id_inst", id_inst, 32'h0);
    chk("adel.id_valid", {31'd0, id_valid}, 32'd1);
    chk("adel.id_pc", id_pc, 32'h102);
`else
    chk("mis.rom_pc", rom_pc, 32'h100);
    chk("mis.rom_ce", {31'd0, rom_ce}, {31'd0, CHIP_ENABLE});
    step();
    chk_id("mis", 32'h100, 1'b1);
`endif

    // Mid-stream reset overrides flush/stall/branch on the same edge
    rst = 1'b1; flush = 1'b1; flush_pc = 32'h500; stall = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h600;
    step();
    chk("mrst.rom_pc", rom_pc, 32'h0);
    chk("mrst.rom_ce", {31'd0, rom_ce}, {31'd0, CHIP_DISABLE});
    chk_id("mrst", 32'h0, 1'b0);
    rst = 1'b0; flush = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    step();
    chk("mrst.rel_pc", rom_pc, 32'h0);
    step();
    chk("mrst.run_pc", rom_pc, 32'h4);
    chk_id("mrst.run", 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
